// File: rtl/uart_word_packer_if.sv
// Byte-in / word-out bus of the UART word packer: frame control, received bytes, memory write port.
interface uart_word_packer_if #(
    parameter int BYTES_PER_WORD = 24,
    parameter int ADDR_W         = 11
);
    logic                        start;
    logic                        rearm;
    logic                        byte_valid;
    logic [7:0]                  byte_data;
    logic                        wr_en;
    logic [ADDR_W-1:0]           wr_addr;
    logic [8*BYTES_PER_WORD-1:0] wr_data;
    logic                        done;
    logic                        overrun;
    logic                        resync;

    modport master (
        output start, rearm, byte_valid, byte_data,
        input  wr_en, wr_addr, wr_data, done, overrun, resync
    );

    modport slave (
        input  start, rearm, byte_valid, byte_data,
        output wr_en, wr_addr, wr_data, done, overrun, resync
    );
endinterface

// File: rtl/uart_word_packer.sv
// Packs UART bytes into BYTES_PER_WORD-wide memory words for one frame of NUM_WORDS words.
// Zero latency: the final byte of a word is written in its own cycle; no backpressure (bytes outside FILL drop and flag overrun).
module uart_word_packer #(
    parameter int BYTES_PER_WORD = 24,
    parameter int ADDR_W         = 11,
    parameter int NUM_WORDS      = 1000,
    parameter bit MSB_FIRST      = 1'b0,
    parameter int TIMEOUT_CYC    = 100000
) (
    input  logic              clock,
    input  logic              reset,
    uart_word_packer_if.slave bus
);
    localparam int PW   = $clog2(BYTES_PER_WORD);
    localparam int AW1  = ADDR_W + 1;
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int WW   = 8 * BYTES_PER_WORD;

    localparam logic [PW-1:0]   POS_LAST  = PW'(BYTES_PER_WORD - 1);
    localparam logic [AW1-1:0]  ADDR_LAST = AW1'(NUM_WORDS - 1);
    localparam logic [TO_W-1:0] TO_LAST   = (TIMEOUT_CYC == 0) ? '0 : TO_W'(TIMEOUT_CYC - 1);
    localparam bit              TO_EN     = (TIMEOUT_CYC != 0);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   pos_q;
    logic [AW1-1:0]  addr_q;
    logic [TO_W-1:0] cnt_q;
    logic [WW-1:0]   word_q;
    logic [WW-1:0]   word_c;
    logic [PW-1:0]   lane;
    logic            overrun_q;

    logic in_fill, last_byte, last_word, word_wr, idle_tick, expire;
    logic wr_en_c, done_c, resync_c;

    assign in_fill   = (state_q == FILL);
    assign last_byte = (pos_q == POS_LAST);
    assign last_word = (addr_q == ADDR_LAST);
    assign word_wr   = in_fill && bus.byte_valid && last_byte;
    // Only a partially filled word can time out; an empty word waits forever.
    assign idle_tick = TO_EN && in_fill && !bus.byte_valid && (pos_q != '0);
    assign expire    = idle_tick && (cnt_q == TO_LAST);

    assign lane = MSB_FIRST ? (POS_LAST - pos_q) : pos_q;

    // Current byte merged into the held lanes so the completing word goes out in the same cycle.
    always_comb begin
        word_c = word_q;
        word_c[8*lane +: 8] = bus.byte_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = FILL;
            FILL:    if (word_wr && last_word) state_d = DONE;
            DONE:    if (bus.rearm) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_en_c  = word_wr;
        done_c   = (state_q == DONE);
        resync_c = expire;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pos_q     <= '0;
            addr_q    <= '0;
            cnt_q     <= '0;
            word_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        pos_q     <= '0;
                        addr_q    <= '0;
                        cnt_q     <= '0;
                        overrun_q <= 1'b0;
                    end
                    if (bus.byte_valid) overrun_q <= 1'b1;
                end
                FILL: begin
                    if (bus.byte_valid) begin
                        word_q <= word_c;
                        cnt_q  <= '0;
                        if (last_byte) begin
                            pos_q  <= '0;
                            addr_q <= addr_q + AW1'(1);
                        end else begin
                            pos_q <= pos_q + PW'(1);
                        end
                    end else if (expire) begin
                        pos_q <= '0;
                        cnt_q <= '0;
                    end else if (idle_tick) begin
                        cnt_q <= cnt_q + TO_W'(1);
                    end
                end
                DONE: begin
                    if (bus.byte_valid) overrun_q <= 1'b1;
                end
                default: begin
                    pos_q <= '0;
                end
            endcase
        end
    end

    assign bus.wr_en   = wr_en_c;
    assign bus.wr_addr = addr_q[ADDR_W-1:0];
    assign bus.wr_data = word_c;
    assign bus.done    = done_c;
    assign bus.overrun = overrun_q;
    assign bus.resync  = resync_c;
endmodule

// File: tb/tb_uart_word_packer.sv
// Directed bench: LSB-first and MSB-first packers (4-byte words, 2-word frames, timeout 10) driven in lockstep.
module tb_uart_word_packer;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clock = ~clock;

    uart_word_packer_if #(.BYTES_PER_WORD(4), .ADDR_W(11)) if_l ();
    uart_word_packer_if #(.BYTES_PER_WORD(4), .ADDR_W(11)) if_m ();

    uart_word_packer #(.BYTES_PER_WORD(4), .ADDR_W(11), .NUM_WORDS(2), .MSB_FIRST(1'b0), .TIMEOUT_CYC(10))
        dut_l (.clock(clock), .reset(reset), .bus(if_l.slave));
    uart_word_packer #(.BYTES_PER_WORD(4), .ADDR_W(11), .NUM_WORDS(2), .MSB_FIRST(1'b1), .TIMEOUT_CYC(10))
        dut_m (.clock(clock), .reset(reset), .bus(if_m.slave));

    typedef struct packed {
        logic        st, ra, bv;
        logic [7:0]  bd;
        logic        e_en;
        logic [10:0] e_addr;
        logic [31:0] e_data;
        logic        e_done, e_ovr, e_rsy;
    } vec_t;

    vec_t vecs [19];

    function automatic logic [31:0] swap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic st, input logic ra, input logic bv, input logic [7:0] bd);
        if_l.start = st; if_l.rearm = ra; if_l.byte_valid = bv; if_l.byte_data = bd;
        if_m.start = st; if_m.rearm = ra; if_m.byte_valid = bv; if_m.byte_data = bd;
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic drive(input logic st, input logic ra, input logic bv, input logic [7:0] bd);
        @(posedge clock);
        #1;
        set_in(st, ra, bv, bd);
        @(negedge clock);
    endtask

    task automatic chk_out(input string tag, input logic e_en, input logic [10:0] e_addr,
                           input logic [31:0] e_data, input logic e_done, input logic e_ovr,
                           input logic e_rsy);
        chk({tag, ".l.wr_en"},   64'(if_l.wr_en),   64'(e_en));
        chk({tag, ".l.wr_addr"}, 64'(if_l.wr_addr), 64'(e_addr));
        chk({tag, ".l.done"},    64'(if_l.done),    64'(e_done));
        chk({tag, ".l.overrun"}, 64'(if_l.overrun), 64'(e_ovr));
        chk({tag, ".l.resync"},  64'(if_l.resync),  64'(e_rsy));
        chk({tag, ".m.wr_en"},   64'(if_m.wr_en),   64'(e_en));
        chk({tag, ".m.wr_addr"}, 64'(if_m.wr_addr), 64'(e_addr));
        chk({tag, ".m.resync"},  64'(if_m.resync),  64'(e_rsy));
        if (e_en) begin
            chk({tag, ".l.wr_data"}, 64'(if_l.wr_data), 64'(e_data));
            chk({tag, ".m.wr_data"}, 64'(if_m.wr_data), 64'(swap32(e_data)));
        end
    endtask

    task automatic send(input string tag, input logic [7:0] b, input logic e_en,
                        input logic [10:0] e_addr, input logic [31:0] e_data);
        drive(1'b0, 1'b0, 1'b1, b);
        chk_out(tag, e_en, e_addr, e_data, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        //          st    ra    bv    bd     en    addr   data           done  ovr   rsy
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 11'd0, 32'h0,        1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 8'hAA, 1'b0, 11'd0, 32'h0,        1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 11'd0, 32'h0,        1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 11'd0, 32'h0,        1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 11'd0, 32'h0,        1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 11'd0, 32'h0,        1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'h02, 1'b0, 11'd0, 32'h0,        1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 8'h03, 1'b0, 11'd0, 32'h0,        1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 8'h04, 1'b1, 11'd0, 32'h04030201, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'h05, 1'b0, 11'd1, 32'h0,        1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 8'h06, 1'b0, 11'd1, 32'h0,        1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 8'h07, 1'b0, 11'd1, 32'h0,        1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 8'h08, 1'b1, 11'd1, 32'h08070605, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 11'd2, 32'h0,        1'b1, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 8'h09, 1'b0, 11'd2, 32'h0,        1'b1, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 11'd2, 32'h0,        1'b1, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 11'd2, 32'h0,        1'b1, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 11'd2, 32'h0,        1'b0, 1'b1, 1'b0};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 11'd2, 32'h0,        1'b0, 1'b1, 1'b0};

        set_in(1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge clock);
        chk_out("reset", 1'b0, 11'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clock);
        #1 reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].st, vecs[i].ra, vecs[i].bv, vecs[i].bd);
            chk_out($sformatf("vec%0d", i), vecs[i].e_en, vecs[i].e_addr, vecs[i].e_data,
                    vecs[i].e_done, vecs[i].e_ovr, vecs[i].e_rsy);
        end

        // Partial word abandoned after 10 idle cycles; next word built from fresh bytes only.
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        send("to.b0", 8'h11, 1'b0, 11'd0, 32'h0);
        send("to.b1", 8'h22, 1'b0, 11'd0, 32'h0);
        for (int i = 1; i <= 9; i++) begin
            drive(1'b0, 1'b0, 1'b0, 8'h00);
            chk_out($sformatf("to.idle%0d", i), 1'b0, 11'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        chk_out("to.expire", 1'b0, 11'd0, 32'h0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        chk_out("to.after", 1'b0, 11'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        send("to.c0", 8'h31, 1'b0, 11'd0, 32'h0);
        send("to.c1", 8'h32, 1'b0, 11'd0, 32'h0);
        send("to.c2", 8'h33, 1'b0, 11'd0, 32'h0);
        send("to.c3", 8'h34, 1'b1, 11'd0, 32'h34333231);

        // A byte landing on the would-be expiry cycle keeps the partial word alive.
        send("race.b0", 8'h41, 1'b0, 11'd1, 32'h0);
        send("race.b1", 8'h42, 1'b0, 11'd1, 32'h0);
        for (int i = 1; i <= 9; i++) begin
            drive(1'b0, 1'b0, 1'b0, 8'h00);
            chk_out($sformatf("race.idle%0d", i), 1'b0, 11'd1, 32'h0, 1'b0, 1'b0, 1'b0);
        end
        send("race.b2", 8'h43, 1'b0, 11'd1, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        chk_out("race.gap", 1'b0, 11'd1, 32'h0, 1'b0, 1'b0, 1'b0);
        send("race.b3", 8'h44, 1'b1, 11'd1, 32'h44434241);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        chk_out("race.done", 1'b0, 11'd2, 32'h0, 1'b1, 1'b0, 1'b0);

        // Reset mid-word, then a clean frame start.
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        send("rst.b0", 8'h51, 1'b0, 11'd0, 32'h0);
        send("rst.b1", 8'h52, 1'b0, 11'd0, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge clock);
        chk_out("rst.held", 1'b0, 11'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clock);
        #1 reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        chk_out("rst.idle", 1'b0, 11'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        send("rst.c0", 8'h61, 1'b0, 11'd0, 32'h0);
        send("rst.c1", 8'h62, 1'b0, 11'd0, 32'h0);
        send("rst.c2", 8'h63, 1'b0, 11'd0, 32'h0);
        send("rst.c3", 8'h64, 1'b1, 11'd0, 32'h64636261);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        chk_out("rst.next", 1'b0, 11'd1, 32'h0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
